// File: rtl/fir_ap_ctrl.sv
// fir_ap_ctrl: ap_start/ap_done/ap_idle sequencer and RAM/MAC scheduler for the FIR engine.
// Optional FIR_CTRL_TLAST_CHECK_EN: flags tlast/length disagreement in status bit 3.
module fir_ap_ctrl #(
    parameter int TAP_NUM_WIDTH  = 10,
    parameter int DATA_NUM_WIDTH = 10
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      in_ap_start_wr,
    input  logic                      in_stat_rd,
    input  logic [TAP_NUM_WIDTH-1:0]  in_tap_num,
    input  logic [31:0]               in_data_len,
    input  logic                      in_ss_tvalid,
    input  logic                      in_ss_tlast,
    output logic                      out_ss_tready,
    input  logic                      in_sm_tready,
    output logic                      out_sm_tvalid,
    output logic                      out_sm_tlast,
    output logic                      out_tap_EN,
    output logic [TAP_NUM_WIDTH-1:0]  out_tap_A,
    output logic                      out_data_EN,
    output logic                      out_data_WE,
    output logic                      out_data_zero,
    output logic [DATA_NUM_WIDTH-1:0] out_data_A,
    output logic                      out_mac_en,
    output logic                      out_mac_clr,
    output logic [3:0]                out_ap_status
);
    localparam int KW = TAP_NUM_WIDTH - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_MAC,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t state;

    logic ap_start;
    logic ap_done;
    logic ap_idle;
    logic err_tlast;

    logic [KW-1:0] n_q;
    logic [KW-1:0] k;
    logic [KW-1:0] ptr;
    logic [KW-1:0] didx;
    logic [31:0]   l_q;
    logic [31:0]   count;
    logic          drain;

    logic                      tap_en;
    logic [TAP_NUM_WIDTH-1:0]  tap_a;
    logic                      data_en_q;
    logic                      data_we_q;
    logic                      data_zero;
    logic [DATA_NUM_WIDTH-1:0] data_a;
    logic                      ss_tready;
    logic                      sm_tvalid;
    logic                      sm_tlast;

    logic mac_d1;
    logic clr_d1;
    logic mac_en;
    logic mac_clr;

    logic [KW-1:0] n_in;
    logic [KW-1:0] n_last;
    logic [KW-1:0] k_inc;
    logic [KW-1:0] ptr_inc;
    logic [KW-1:0] didx_dec;
    logic [31:0]   count_inc;
    logic          ss_fire;
    logic [2:0]    unused_in;

    assign n_in      = in_tap_num[KW-1:0];
    assign n_last    = n_q - KW'(1);
    assign k_inc     = k + KW'(1);
    assign ptr_inc   = (ptr == n_last) ? '0 : ptr + KW'(1);
    assign didx_dec  = (didx == '0) ? n_last : didx - KW'(1);
    assign count_inc = count + 32'd1;
    assign ss_fire   = ss_tready & in_ss_tvalid;
    assign unused_in = {in_tap_num[TAP_NUM_WIDTH-1:KW], in_ss_tlast};

    function automatic logic [DATA_NUM_WIDTH-1:0] daddr(input logic [KW-1:0] idx);
        return DATA_NUM_WIDTH'({idx, 2'b00});
    endfunction

    function automatic logic [TAP_NUM_WIDTH-1:0] taddr(input logic [KW-1:0] idx);
        return {idx, 2'b00};
    endfunction

    // Control FSM: state, status word and registered RAM/stream strobes
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            ap_start  <= 1'b0;
            ap_done   <= 1'b0;
            ap_idle   <= 1'b1;
            err_tlast <= 1'b0;
            n_q       <= '0;
            l_q       <= '0;
            count     <= '0;
            k         <= '0;
            ptr       <= '0;
            didx      <= '0;
            drain     <= 1'b0;
            tap_en    <= 1'b0;
            tap_a     <= '0;
            data_en_q <= 1'b0;
            data_we_q <= 1'b0;
            data_zero <= 1'b0;
            data_a    <= '0;
            ss_tready <= 1'b0;
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
        end else begin
            tap_en    <= 1'b0;
            data_en_q <= 1'b0;
            data_we_q <= 1'b0;
            data_zero <= 1'b0;
            if (in_stat_rd) ap_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        ap_start  <= 1'b0;
                        ap_done   <= 1'b0;
                        err_tlast <= 1'b0;
                        n_q       <= n_in;
                        l_q       <= in_data_len;
                        count     <= '0;
                        ptr       <= '0;
                        k         <= '0;
                        if (n_in == '0 || in_data_len == 32'd0) begin
                            state   <= S_DONE;
                            ap_done <= 1'b1;
                            ap_idle <= 1'b1;
                        end else begin
                            state     <= S_CLEAR;
                            ap_idle   <= 1'b0;
                            data_en_q <= 1'b1;
                            data_we_q <= 1'b1;
                            data_zero <= 1'b1;
                            data_a    <= '0;
                        end
                    end else if (in_ap_start_wr) begin
                        ap_start <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (k == n_last) begin
                        state     <= S_WAIT;
                        k         <= '0;
                        ss_tready <= 1'b1;
                        data_a    <= daddr(ptr);
                    end else begin
                        k         <= k_inc;
                        data_en_q <= 1'b1;
                        data_we_q <= 1'b1;
                        data_zero <= 1'b1;
                        data_a    <= daddr(k_inc);
                    end
                end
                S_WAIT: begin
                    if (in_ss_tvalid) begin
                        state     <= S_MAC;
                        ss_tready <= 1'b0;
                        count     <= count_inc;
`ifdef FIR_CTRL_TLAST_CHECK_EN
                        if (in_ss_tlast != (count_inc == l_q))
                            err_tlast <= 1'b1;
`endif
                        k         <= '0;
                        didx      <= ptr;
                        tap_en    <= 1'b1;
                        tap_a     <= '0;
                        data_en_q <= 1'b1;
                        data_a    <= daddr(ptr);
                    end
                end
                S_MAC: begin
                    if (k == n_last) begin
                        state <= S_DRAIN;
                        drain <= 1'b0;
                        ptr   <= ptr_inc;
                        k     <= '0;
                        tap_a <= '0;
                    end else begin
                        k         <= k_inc;
                        didx      <= didx_dec;
                        tap_en    <= 1'b1;
                        tap_a     <= taddr(k_inc);
                        data_en_q <= 1'b1;
                        data_a    <= daddr(didx_dec);
                    end
                end
                S_DRAIN: begin
                    if (drain) begin
                        state     <= S_OUT;
                        sm_tvalid <= 1'b1;
                        sm_tlast  <= (count == l_q);
                    end else begin
                        drain <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (in_sm_tready) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        if (count < l_q) begin
                            state     <= S_WAIT;
                            ss_tready <= 1'b1;
                            data_a    <= daddr(ptr);
                        end else begin
                            state   <= S_DONE;
                            ap_done <= 1'b1;
                            ap_idle <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // MAC control trails the RAM read issue by two cycles (read + multiply)
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mac_d1  <= 1'b0;
            clr_d1  <= 1'b0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
        end else begin
            mac_d1  <= tap_en;
            clr_d1  <= tap_en & (tap_a == '0);
            mac_en  <= mac_d1;
            mac_clr <= clr_d1;
        end
    end

    assign out_ss_tready = ss_tready;
    assign out_sm_tvalid = sm_tvalid;
    assign out_sm_tlast  = sm_tlast;
    assign out_tap_EN    = tap_en;
    assign out_tap_A     = tap_a;
    assign out_data_EN   = data_en_q | ss_fire;
    assign out_data_WE   = data_we_q | ss_fire;
    assign out_data_zero = data_zero;
    assign out_data_A    = data_a;
    assign out_mac_en    = mac_en;
    assign out_mac_clr   = mac_clr;

`ifdef FIR_CTRL_TLAST_CHECK_EN
    assign out_ap_status = {err_tlast, ap_idle, ap_done, ap_start};
`else
    assign out_ap_status = {1'b0, ap_idle, ap_done, ap_start};
`endif

endmodule

// File: doc/fir_ap_ctrl.md
# fir_ap_ctrl

Block-level sequencer for the FIR engine inside `fir_top`.
- Owns the ap_start/ap_done/ap_idle control word.
- Latches tap count and data length at start, then zero-fills the data RAM shift window.
- Per sample: accepts one AXI-Stream input, schedules one MAC pass over tap RAM and data RAM (circular buffer), and releases one AXI-Stream output.
- Drives RAM enables/addresses and MAC control only; the multiplier/accumulator datapath and the AXI-Lite decode live elsewhere.

## Interface
Parameters:
- TAP_NUM_WIDTH, 10, width of tap RAM byte address
- DATA_NUM_WIDTH, 10, width of data RAM byte address

Ports (all synchronous to aclk unless noted):
- aclk  in  1  single clock
- areset  in  1  asynchronous reset, active-high
- in_ap_start_wr  in  1  one-cycle pulse: AXI-Lite write to 0x00 with wdata[0]=1
- in_stat_rd  in  1  one-cycle pulse: AXI-Lite read of 0x00 accepted
- in_tap_num  in  TAP_NUM_WIDTH  tap count register (0x10)
- in_data_len  in  32  sample count register (0x20)
- in_ss_tvalid  in  1  input stream valid
- in_ss_tlast  in  1  input stream last
- out_ss_tready  out  1  input stream ready
- in_sm_tready  in  1  output stream ready
- out_sm_tvalid  out  1  output stream valid
- out_sm_tlast  out  1  output stream last
- out_tap_EN  out  1  tap RAM enable (read only)
- out_tap_A  out  TAP_NUM_WIDTH  tap RAM byte address
- out_data_EN  out  1  data RAM enable
- out_data_WE  out  1  data RAM write
- out_data_zero  out  1  datapath drives data_Di=0 (else ss_tdata)
- out_data_A  out  DATA_NUM_WIDTH  data RAM byte address
- out_mac_en  out  1  accumulate product this cycle
- out_mac_clr  out  1  load product instead of accumulate (with first mac_en)
- out_ap_status  out  4  {err_tlast, ap_idle, ap_done, ap_start}

## Operation
- Reset values:
  - State: IDLE.
  - out_ap_status = 4'b0100.
  - All enables, valids, readies, mac_* and *_A = 0.
  - Sample count = 0; ptr = 0.
  - RAM contents are not touched.
- Addresses are byte addresses, word index × 4.
- ap_start:
  - Set by in_ap_start_wr only in IDLE; ignored otherwise.
  - Cleared on the cycle the FSM leaves IDLE.
- On leaving IDLE:
  - N = in_tap_num and L = in_data_len are latched.
  - Later register writes have no effect on this run.
- States:
  - IDLE: ap_idle=1. When ap_start=1: go to CLEAR; ap_idle←0; ap_done←0; err_tlast←0. If N=0 or L=0, go instead to DONE with no stream or RAM activity.
  - CLEAR: N cycles, data_EN=WE=zero=1, data_A = 0,4,…,4(N−1). Then WAIT_SS with ptr=0.
  - WAIT_SS: ss_tready=1. On tvalid: data_EN=WE=1, data_A=4·ptr (same cycle), count++. Then MAC.
  - MAC: N cycles, k=0..N−1. tap_EN=1, tap_A=4k, data_EN=1, WE=0, data_A=4·((ptr−k) mod N). After the pass, ptr←(ptr+1) mod N. Then DRAIN.
  - DRAIN: 2 cycles, no RAM access. Then OUT.
  - OUT: sm_tvalid=1, held until sm_tready. sm_tlast=1 when count=L. On handshake: if count<L go to WAIT_SS, else DONE.
  - DONE: ap_done←1, ap_idle←1, go to IDLE (1 cycle).
- ap_done:
  - Sticky.
  - Cleared by in_stat_rd or by the next start.
  - If set and in_stat_rd occur in the same cycle, set wins.
- out_mac_en = MAC-issue valid delayed 2 cycles (RAM read + registered multiply).
- out_mac_clr = out_mac_en for k=0 only.
- Counters: count is 32 bits; k and ptr are TAP_NUM_WIDTH−2 bits; N ≤ 2^(TAP_NUM_WIDTH−2)−1.

## Timing
- Start accepted at cycle S: first CLEAR write at S+1; ss_tready first high at S+N+1.
- Sample accepted at cycle T:
  - MAC issues at T+1..T+N.
  - Final mac_en at T+N+2.
  - sm_tvalid at T+N+3.
- Throughput with no backpressure: N+4 cycles per sample.
- ss_tready is 0 outside WAIT_SS. Backpressure on the output stalls everything; no RAM access while stalled in OUT.
- ap_done and ap_idle rise 1 cycle after the final sm handshake.
- areset asserted at any time: outputs take reset values immediately (async). A partial run is abandoned and data RAM must be re-cleared by the next start.

## Configuration
- FIR_CTRL_TLAST_CHECK_EN defined:
  - err_tlast (status bit 3) is set sticky if in_ss_tlast=1 on an accepted sample with count≠L, or tlast=0 with count=L.
  - Processing still runs to exactly L samples.
- Not defined: in_ss_tlast is ignored and bit 3 is tied 0.

## Test plan
- Reset: areset=1 for 3 cycles -> status=4'h4, ss_tready=0, sm_tvalid=0, all EN=0.
- N=11, L=3, start, ss_tvalid and sm_tready always 1:
  - 11 zero writes, addresses 0..40.
  - Sample writes at 0, 4, 8.
  - First MAC pass data_A=0,40,36…4; tap_A=0..40.
  - sm_tvalid 14 cycles after each accept.
  - tlast only on output 3.
  - Status read during run is 4'h0; after the run it is 4'h6.
- Backpressure: sm_tready=0 for 5 cycles in OUT -> sm_tvalid held, ss_tready=0, no RAM EN, then completes normally.
- Wrap: N=2, L=5 -> sample writes at 0, 4, 0, 4, 0; 5 outputs.
- tlast on sample 2 of L=4:
  - With macro: bit3=1 and 4 outputs.
  - Without macro: bit3=0.
- Edge cases:
  - Start write while busy is ignored.
  - in_stat_rd after done -> status 4'h4.
  - areset mid-MAC -> status 4'h4, all outputs 0 immediately.
  - N=0 with start -> status 4'h6 two cycles later, no stream activity.
